// File: rtl/aes_state_iter.sv
// Iterative AES state register: load, NROUNDS external round updates, drain.
// Owns the round counter and the valid/ready sequencing around the datapath.
module aes_state_iter #(
  parameter  int WIDTH   = 128,
  parameter  int NROUNDS = 10,
  localparam int RCW     = $clog2(NROUNDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_state,
  input  logic             round_en,
  input  logic [WIDTH-1:0] round_state,
  output logic [WIDTH-1:0] curr_state,
  output logic [RCW-1:0]   round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_state,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  st_t  st;
  logic last;

  assign last = (round == RCW'(NROUNDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      curr_state <= '0;
      round      <= '0;
    end else if (flush) begin
      st    <= IDLE;
      round <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            curr_state <= in_state;
            round      <= RCW'(1);
            st         <= RUN;
          end
        end
        RUN: begin
          if (round_en) begin
            curr_state <= round_state;
            if (last) st <= DONE;
            else      round <= round + RCW'(1);
          end
        end
        DONE: begin
          // back-to-back: a waiting block loads on the drain edge
          if (out_ready) begin
            if (in_valid) begin
              curr_state <= in_state;
              round      <= RCW'(1);
              st         <= RUN;
            end else begin
              round <= '0;
              st    <= IDLE;
            end
          end
        end
        default: begin
          st    <= IDLE;
          round <= '0;
        end
      endcase
    end
  end

  assign in_ready  = !reset && !flush &&
                     ((st == IDLE) || ((st == DONE) && out_ready));
  assign out_valid = (st == DONE);
  assign out_state = curr_state;
  assign busy      = (st != IDLE);

endmodule

// File: tb/tb_aes_state_iter.sv
// Bench for aes_state_iter: directed scenarios plus a randomized run
// scored against a block-level model (result = load + sum(1..N)).
module tb_aes_state_iter;

  localparam int W = 128;

  logic         clk = 0;
  logic         reset, flush, in_valid, round_en, out_ready;
  logic [W-1:0] in_state, rs, cs, os;
  logic [3:0]   rnd;
  logic         in_ready, out_valid, busy;

  logic         b_in_valid, b_in_ready, b_out_valid, b_busy;
  logic [W-1:0] b_in_state, b_rs, b_cs, b_os;
  logic [0:0]   b_rnd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rs   = cs + W'(rnd);
  assign b_rs = b_cs + W'(b_rnd);

  aes_state_iter #(.WIDTH(W), .NROUNDS(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .round_en(round_en), .round_state(rs), .curr_state(cs),
    .round(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(os), .busy(busy)
  );

  aes_state_iter #(.WIDTH(W), .NROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
    .round_en(round_en), .round_state(b_rs), .curr_state(b_cs),
    .round(b_rnd), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_state(b_os), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept edge counts as edge 1; stalls drop round_en on listed edges
  task automatic run_to_done(input int s0, input int s1, input int s2,
                             output int edges);
    logic [W-1:0] pc;
    logic [3:0]   pr;
    edges = 1;
    while (!out_valid && edges < 60) begin
      round_en = !(edges == s0 || edges == s1 || edges == s2);
      pc = cs;
      pr = rnd;
      step();
      edges++;
      if (!round_en) begin
        chk("stall_state", cs, pc);
        chk("stall_round", W'(rnd), W'(pr));
      end
    end
    round_en = 1;
  endtask

  task automatic load(input logic [W-1:0] v);
    in_valid = 1;
    in_state = v;
    step();
    in_valid = 0;
  endtask

  int           e;
  logic [W-1:0] sv;
  bit           have;
  int           need;
  logic [W-1:0] expv;
  bit           acc;

  initial begin
    reset = 1; flush = 0; in_valid = 0; round_en = 1; out_ready = 0;
    in_state = '0; b_in_valid = 0; b_in_state = '0;
    step();
    chk("rst_ready", W'(in_ready), 0);
    reset = 0;
    #1;
    chk("post_rst_ready", W'(in_ready), 1);
    chk("post_rst_busy", W'(busy), 0);

    // reset mid-RUN at round 5
    load(W'(5));
    repeat (4) step();
    chk("mid_round5", W'(rnd), 5);
    reset = 1;
    step();
    chk("rst_busy", W'(busy), 0);
    chk("rst_state", cs, 0);
    chk("rst_round", W'(rnd), 0);
    chk("rst_ovalid", W'(out_valid), 0);
    chk("rst_iready", W'(in_ready), 0);
    reset = 0;
    #1;
    chk("rst_iready1", W'(in_ready), 1);

    // plain block
    load('0);
    chk("run_iready", W'(in_ready), 0);
    run_to_done(-1, -1, -1, e);
    chk("lat11", W'(e), 11);
    chk("out37", os, W'(8'h37));
    chk("done_round", W'(rnd), 10);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("drain_busy", W'(busy), 0);
    chk("drain_round", W'(rnd), 0);
    chk("drain_hold", cs, W'(8'h37));

    // three stalls
    load('0);
    run_to_done(3, 6, 8, e);
    chk("lat14", W'(e), 14);
    chk("stall_out", os, W'(8'h37));

    // backpressure in DONE with a waiting block
    in_valid = 1;
    in_state = W'(12'h100);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_iready", W'(in_ready), 0);
      step();
      chk("bp_out", os, W'(8'h37));
      chk("bp_valid", W'(out_valid), 1);
    end
    out_ready = 1;
    #1;
    chk("b2b_iready", W'(in_ready), 1);
    step();
    in_valid = 0;
    out_ready = 0;
    chk("b2b_round", W'(rnd), 1);
    chk("b2b_state", cs, W'(12'h100));
    run_to_done(-1, -1, -1, e);
    chk("b2b_lat", W'(e), 11);
    chk("b2b_out", os, W'(12'h137));

    // flush in DONE with a concurrent offer
    flush = 1; in_valid = 1; out_ready = 1;
    #1;
    chk("fl_done_iready", W'(in_ready), 0);
    step();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("fl_done_busy", W'(busy), 0);
    chk("fl_done_ovalid", W'(out_valid), 0);
    chk("fl_done_round", W'(rnd), 0);

    // flush at round 7
    load('0);
    repeat (6) step();
    chk("fl_r7", W'(rnd), 7);
    sv = cs;
    flush = 1; in_valid = 1; in_state = W'(99);
    #1;
    chk("fl_run_iready", W'(in_ready), 0);
    step();
    flush = 0; in_valid = 0;
    chk("fl_run_busy", W'(busy), 0);
    chk("fl_run_round", W'(rnd), 0);
    chk("fl_run_state", cs, sv);
    chk("fl_run_ovalid", W'(out_valid), 0);

    // NROUNDS=1 instance
    b_in_valid = 1;
    b_in_state = W'(8'h10);
    step();
    b_in_valid = 0;
    e = 1;
    while (!b_out_valid && e < 20) begin
      step();
      e++;
    end
    chk("n1_lat", W'(e), 2);
    chk("n1_out", b_os, W'(8'h11));

    // randomized run against the block-level model
    reset = 1;
    step();
    reset = 0;
    have = 0;
    need = 0;
    expv = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      round_en  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      acc = !flush && (!have || (need == 0 && out_ready));
      chk("r_iready", W'(in_ready), W'(acc));
      chk("r_ovalid", W'(out_valid), W'(have && need == 0));
      chk("r_rmax", W'(rnd <= 4'd10), 1);
      if (have && need == 0 && out_ready && !flush)
        chk("r_out", os, expv);
      if (flush) begin
        have = 0;
      end else if (have && need > 0) begin
        if (round_en) need--;
      end else if (acc) begin
        have = in_valid;
        if (in_valid) begin
          expv = in_state + W'(55);
          need = 10;
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
